// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the fetch PC redirect controller: word-address PC,
// redirect source and sequencer state encodings.
package pc_redirect_ctrl_pkg;
  localparam int PC_W = 30;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {SRC_SEQ, SRC_BP, SRC_ID, SRC_EX} redir_src_t;
  typedef enum logic [1:0] {RS_RUN, RS_HOLD, RS_HALT} redir_state_t;
endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the hazard unit / branch predictor / PC register and the
// redirect controller. slave = controller side, master = environment side.
interface pc_redirect_ctrl_if;
  import pc_redirect_ctrl_pkg::*;

  logic fetch_rdy;
  logic stall;
  logic halt;
  pc_t  cpc;
  logic ex_req;
  pc_t  ex_pc;
  logic id_req;
  pc_t  id_pc;
  logic bp_req;
  pc_t  bp_pc;
  logic pc_en;
  pc_t  pc_next;
  logic flush_ifid;
  logic flush_idex;
  logic busy;

  modport slave (
    input  fetch_rdy, stall, halt, cpc, ex_req, ex_pc, id_req, id_pc, bp_req, bp_pc,
    output pc_en, pc_next, flush_ifid, flush_idex, busy
  );

  modport master (
    output fetch_rdy, stall, halt, cpc, ex_req, ex_pc, id_req, id_pc, bp_req, bp_pc,
    input  pc_en, pc_next, flush_ifid, flush_idex, busy
  );
endinterface

// File: rtl/pc_redirect_ctrl_redir_arb.sv
// Combinational priority select of the next-PC source:
// live EX > pending EX > ID > pending ID > predictor > sequential.
module redir_arb
  import pc_redirect_ctrl_pkg::*;
(
  input  logic       ex_v_i,
  input  pc_t        ex_pc_i,
  input  logic       pend_v_i,
  input  redir_src_t pend_src_i,
  input  pc_t        pend_pc_i,
  input  logic       id_v_i,
  input  pc_t        id_pc_i,
  input  logic       bp_v_i,
  input  pc_t        bp_pc_i,
  input  pc_t        cpc_i,
  output redir_src_t src_o,
  output pc_t        target_o
);

  always_comb begin
    src_o    = SRC_SEQ;
    target_o = cpc_i + pc_t'(1);
    if (ex_v_i) begin
      src_o    = SRC_EX;
      target_o = ex_pc_i;
    end else if (pend_v_i && pend_src_i == SRC_EX) begin
      src_o    = SRC_EX;
      target_o = pend_pc_i;
    end else if (id_v_i) begin
      src_o    = SRC_ID;
      target_o = id_pc_i;
    end else if (pend_v_i) begin
      src_o    = SRC_ID;
      target_o = pend_pc_i;
    end else if (bp_v_i) begin
      src_o    = SRC_BP;
      target_o = bp_pc_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates redirects, holds one across I-cache misses
// and raises wrong-path flushes. PC_REDIRECT_STATS_EN adds applied-redirect counters.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter pc_t PC_INIT = '0
) (
  input logic CLK,
  input logic RST,
  pc_redirect_ctrl_if.slave bus
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] ex_cnt,
  output logic [31:0] id_cnt,
  output logic [31:0] bp_cnt
`endif
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0] state_q, state_d;
  logic       init_q;
  logic       pend_v_q, pend_v_d;
  redir_src_t pend_src_q, pend_src_d;
  pc_t        pend_pc_q, pend_pc_d;

  logic       pc_en_c, flush_ifid_c, flush_idex_c;
  pc_t        pc_next_c;
  redir_src_t arb_src;
  pc_t        arb_target;

  // ID and predictor requests only compete while running; stall gates both.
  redir_arb u_arb (
    .ex_v_i    (bus.ex_req),
    .ex_pc_i   (bus.ex_pc),
    .pend_v_i  (pend_v_q),
    .pend_src_i(pend_src_q),
    .pend_pc_i (pend_pc_q),
    .id_v_i    (bus.id_req & ~bus.stall & (state_q == ST_RUN)),
    .id_pc_i   (bus.id_pc),
    .bp_v_i    (bus.bp_req & bus.fetch_rdy & ~bus.stall & (state_q == ST_RUN)),
    .bp_pc_i   (bus.bp_pc),
    .cpc_i     (bus.cpc),
    .src_o     (arb_src),
    .target_o  (arb_target)
  );

  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_src_d   = pend_src_q;
    pend_pc_d    = pend_pc_q;
    pc_en_c      = 1'b0;
    pc_next_c    = arb_target;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    if (bus.halt || state_q == ST_HALT) begin
      state_d  = ST_HALT;
      pend_v_d = 1'b0;
    end else if (init_q) begin
      pc_en_c   = 1'b1;
      pc_next_c = PC_INIT;
    end else if (state_q == ST_HOLD) begin
      flush_ifid_c = 1'b1;
      if (bus.ex_req) begin
        flush_idex_c = 1'b1;
        pend_v_d     = 1'b1;
        pend_src_d   = SRC_EX;
        pend_pc_d    = bus.ex_pc;
      end
      if (bus.fetch_rdy) begin
        pc_en_c  = 1'b1;
        pend_v_d = 1'b0;
        state_d  = ST_RUN;
      end
    end else begin
      case (arb_src)
        SRC_EX, SRC_ID: begin
          flush_ifid_c = 1'b1;
          flush_idex_c = (arb_src == SRC_EX);
          if (bus.fetch_rdy) begin
            pc_en_c = 1'b1;
          end else begin
            pend_v_d   = 1'b1;
            pend_src_d = arb_src;
            pend_pc_d  = arb_target;
            state_d    = ST_HOLD;
          end
        end
        SRC_BP:  pc_en_c = 1'b1;
        default: pc_en_c = bus.fetch_rdy & ~bus.stall;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RUN;
      init_q     <= 1'b1;
      pend_v_q   <= 1'b0;
      pend_src_q <= SRC_SEQ;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b0;
      pend_v_q   <= pend_v_d;
      pend_src_q <= pend_src_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign bus.pc_en      = ~RST & pc_en_c;
  assign bus.pc_next    = RST ? PC_INIT : pc_next_c;
  assign bus.flush_ifid = ~RST & flush_ifid_c;
  assign bus.flush_idex = ~RST & flush_idex_c;
  assign bus.busy       = ~RST & (state_q == ST_HOLD);

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] ex_cnt_q, id_cnt_q, bp_cnt_q;

  // The post-reset PC_INIT load is not a redirect and is not counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_cnt_q <= '0;
      id_cnt_q <= '0;
      bp_cnt_q <= '0;
    end else if (pc_en_c && !init_q) begin
      if (arb_src == SRC_EX && ex_cnt_q != '1) ex_cnt_q <= ex_cnt_q + 32'd1;
      if (arb_src == SRC_ID && id_cnt_q != '1) id_cnt_q <= id_cnt_q + 32'd1;
      if (arb_src == SRC_BP && bp_cnt_q != '1) bp_cnt_q <= bp_cnt_q + 32'd1;
    end
  end

  assign ex_cnt = ex_cnt_q;
  assign id_cnt = id_cnt_q;
  assign bp_cnt = bp_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; counter checks build only with
// PC_REDIRECT_STATS_EN defined.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pc_redirect_ctrl_if bus ();

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] ex_cnt, id_cnt, bp_cnt;
`endif

  pc_redirect_ctrl #(.PC_INIT(30'h0)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .ex_cnt(ex_cnt),
    .id_cnt(id_cnt),
    .bp_cnt(bp_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic en, input logic fi, input logic fx);
    chk({tag, ".pc_en"}, 32'(bus.pc_en), 32'(en));
    chk({tag, ".flush_ifid"}, 32'(bus.flush_ifid), 32'(fi));
    chk({tag, ".flush_idex"}, 32'(bus.flush_idex), 32'(fx));
  endtask

  // Inputs change 1 ns after the rising edge; outputs sampled 2 ns later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    RST           = 1'b1;
    bus.fetch_rdy = 1'b0;
    bus.stall     = 1'b0;
    bus.halt      = 1'b0;
    bus.cpc       = '0;
    bus.ex_req    = 1'b0;
    bus.ex_pc     = '0;
    bus.id_req    = 1'b0;
    bus.id_pc     = '0;
    bus.bp_req    = 1'b0;
    bus.bp_pc     = '0;
    repeat (3) cyc();
    settle();
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.pc_next", 32'(bus.pc_next), 32'h0);
    chk("rst.busy", 32'(bus.busy), 32'h0);

    cyc(); RST = 1'b0; bus.fetch_rdy = 1'b1; settle();
    chk_ctl("init", 1'b1, 1'b0, 1'b0);
    chk("init.pc_next", 32'(bus.pc_next), 32'h0);

    for (int i = 0; i < 4; i++) begin
      cyc(); bus.cpc = pc_t'(i); settle();
      chk("seq.pc_en", 32'(bus.pc_en), 32'h1);
      chk("seq.pc_next", 32'(bus.pc_next), 32'(i + 1));
    end

    cyc(); bus.cpc = 30'h10; bus.ex_req = 1'b1; bus.ex_pc = 30'h40; settle();
    chk_ctl("ex_hit", 1'b1, 1'b1, 1'b1);
    chk("ex_hit.pc_next", 32'(bus.pc_next), 32'h40);

    cyc(); bus.ex_req = 1'b0; bus.id_req = 1'b1; bus.id_pc = 30'h80; bus.fetch_rdy = 1'b0; settle();
    chk_ctl("id_miss", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.id_req = 1'b0; settle();
      chk_ctl("id_hold", 1'b0, 1'b1, 1'b0);
      chk("id_hold.busy", 32'(bus.busy), 32'h1);
    end
    cyc(); bus.fetch_rdy = 1'b1; settle();
    chk_ctl("id_apply", 1'b1, 1'b1, 1'b0);
    chk("id_apply.pc_next", 32'(bus.pc_next), 32'h80);
    cyc(); bus.cpc = 30'h80; settle();
    chk("id_after.busy", 32'(bus.busy), 32'h0);
    chk_ctl("id_after", 1'b1, 1'b0, 1'b0);
    chk("id_after.pc_next", 32'(bus.pc_next), 32'h81);

    cyc(); bus.cpc = 30'h10; bus.id_req = 1'b1; bus.id_pc = 30'h80; bus.fetch_rdy = 1'b0; settle();
    cyc(); bus.id_req = 1'b0; bus.ex_req = 1'b1; bus.ex_pc = 30'h20; settle();
    chk_ctl("hold_ex", 1'b0, 1'b1, 1'b1);
    chk("hold_ex.busy", 32'(bus.busy), 32'h1);
    cyc(); bus.ex_req = 1'b0; settle();
    chk_ctl("hold_ex2", 1'b0, 1'b1, 1'b0);
    cyc(); bus.fetch_rdy = 1'b1; settle();
    chk("hold_ex_apply.pc_en", 32'(bus.pc_en), 32'h1);
    chk("hold_ex_apply.pc_next", 32'(bus.pc_next), 32'h20);
    cyc(); bus.cpc = 30'h20; settle();
    chk("hold_ex_after.busy", 32'(bus.busy), 32'h0);

    cyc(); bus.stall = 1'b1; bus.bp_req = 1'b1; bus.bp_pc = 30'h99; settle();
    chk_ctl("bp_stall", 1'b0, 1'b0, 1'b0);
    cyc(); bus.stall = 1'b0; bus.bp_req = 1'b0; settle();
    chk("bp_drop.pc_en", 32'(bus.pc_en), 32'h1);
    chk("bp_drop.pc_next", 32'(bus.pc_next), 32'h21);
    cyc(); bus.bp_req = 1'b1; settle();
    chk_ctl("bp_take", 1'b1, 1'b0, 1'b0);
    chk("bp_take.pc_next", 32'(bus.pc_next), 32'h99);
    cyc(); bus.fetch_rdy = 1'b0; settle();
    chk_ctl("bp_miss", 1'b0, 1'b0, 1'b0);
    cyc(); bus.bp_req = 1'b0; bus.fetch_rdy = 1'b1; settle();
    chk("bp_miss_drop.pc_next", 32'(bus.pc_next), 32'h21);
    chk("bp_miss_drop.busy", 32'(bus.busy), 32'h0);

    cyc(); bus.cpc = 30'h3FFFFFFF; settle();
    chk("wrap.pc_next", 32'(bus.pc_next), 32'h0);

    cyc(); bus.cpc = 30'h30; bus.stall = 1'b1; bus.id_req = 1'b1; bus.id_pc = 30'h55; settle();
    chk_ctl("id_stall", 1'b0, 1'b0, 1'b0);
    cyc(); bus.stall = 1'b0; bus.ex_req = 1'b1; bus.ex_pc = 30'h66; settle();
    chk_ctl("ex_id", 1'b1, 1'b1, 1'b1);
    chk("ex_id.pc_next", 32'(bus.pc_next), 32'h66);
    cyc(); bus.ex_req = 1'b0; settle();
    chk_ctl("id_hit", 1'b1, 1'b1, 1'b0);
    chk("id_hit.pc_next", 32'(bus.pc_next), 32'h55);
    cyc(); bus.id_req = 1'b0; settle();
`ifdef PC_REDIRECT_STATS_EN
    chk("cnt.ex", ex_cnt, 32'd3);
    chk("cnt.id", id_cnt, 32'd2);
    chk("cnt.bp", bp_cnt, 32'd1);
`endif

    cyc(); bus.halt = 1'b1; bus.ex_req = 1'b1; bus.ex_pc = 30'h40; settle();
    chk_ctl("halt", 1'b0, 1'b0, 1'b0);
    cyc(); bus.halt = 1'b0; settle();
    chk_ctl("halted_ex", 1'b0, 1'b0, 1'b0);
    cyc(); bus.ex_req = 1'b0; settle();
    chk_ctl("halted_seq", 1'b0, 1'b0, 1'b0);
`ifdef PC_REDIRECT_STATS_EN
    chk("cnt.ex_halt", ex_cnt, 32'd3);
`endif

    cyc(); RST = 1'b1; settle();
    chk_ctl("halt_rst", 1'b0, 1'b0, 1'b0);
    cyc(); RST = 1'b0; settle();
    chk_ctl("halt_rel", 1'b1, 1'b0, 1'b0);
    chk("halt_rel.pc_next", 32'(bus.pc_next), 32'h0);
`ifdef PC_REDIRECT_STATS_EN
    chk("cnt.ex_rst", ex_cnt, 32'd0);
`endif

    cyc(); bus.cpc = 30'h0; bus.id_req = 1'b1; bus.id_pc = 30'h77; bus.fetch_rdy = 1'b0; settle();
    cyc(); bus.id_req = 1'b0; settle();
    chk("hold_pre_rst.busy", 32'(bus.busy), 32'h1);
    cyc(); RST = 1'b1; settle();
    chk("hold_rst.busy", 32'(bus.busy), 32'h0);
    cyc(); RST = 1'b0; bus.fetch_rdy = 1'b1; settle();
    chk("hold_rel.pc_next", 32'(bus.pc_next), 32'h0);
    cyc(); bus.cpc = 30'h0; settle();
    chk("hold_lost.pc_next", 32'(bus.pc_next), 32'h1);
    chk_ctl("hold_lost", 1'b1, 1'b0, 1'b0);
    chk("hold_lost.busy", 32'(bus.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
